// File: rtl/uart_rx.sv
// -----------------------------------------------------------------------------
// uart_rx -- oversampling asynchronous serial receiver (8N1 by default).
//
// The serial line is double-flopped into the clk domain, and the baud
// generator's toggling rx_tick is edge-detected into a one-cycle tick. Each
// bit period is OVERSAMPLE ticks. The start bit is re-checked half a bit
// after its falling edge. After that, every OVERSAMPLE ticks lands close to
// the middle of the next data or stop bit.
//
// Ports
//   clk          system clock, all state changes on its rising edge
//   rst          synchronous active-high reset
//   rx_tick      oversample timebase; every level change is one tick
//   rx           asynchronous serial input, idles high
//   rx_data      last received word (DATA_BITS wide)
//   rx_valid     rx_data holds a word the consumer has not yet taken
//   rx_ready     consumer takes rx_data in this cycle
//   frame_err    one-cycle pulse: stop bit sampled low
//   overrun_err  one-cycle pulse: a completed word was dropped
//   state_dbg    current FSM state (IDLE=0 START=1 DATA=2 STOP=3 WAIT_HIGH=4)
//
// Handshake (rx_valid / rx_ready): a word is transferred on every rising clk
// edge where rx_valid and rx_ready are both 1. While rx_valid is 1, rx_data
// holds steady until that transfer. The one exception is a new word that
// completes in the transfer cycle: that word replaces the old one and
// rx_valid stays 1. rx_ready has no effect while rx_valid is 0. If a word
// completes while rx_valid is 1 and rx_ready is 0, the new word is dropped
// and overrun_err pulses.
// -----------------------------------------------------------------------------
module uart_rx #(
    parameter int DATA_BITS  = 8,
    parameter int OVERSAMPLE = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 rx_tick,
    input  logic                 rx,
    output logic [DATA_BITS-1:0] rx_data,
    output logic                 rx_valid,
    input  logic                 rx_ready,
    output logic                 frame_err,
    output logic                 overrun_err,
    output logic [2:0]           state_dbg
);

    localparam int CNT_W = (OVERSAMPLE > 1) ? $clog2(OVERSAMPLE) : 1;
    localparam int BIT_W = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;

    localparam logic [CNT_W-1:0] CNT_HALF = CNT_W'(OVERSAMPLE / 2 - 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(OVERSAMPLE - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(DATA_BITS - 1);
    localparam logic [BIT_W-1:0] BIT_ONE  = BIT_W'(1);

    localparam logic [2:0] S_IDLE      = 3'd0;
    localparam logic [2:0] S_START     = 3'd1;
    localparam logic [2:0] S_DATA      = 3'd2;
    localparam logic [2:0] S_STOP      = 3'd3;
    localparam logic [2:0] S_WAIT_HIGH = 3'd4;

    // ------------------------------------------------------------------
    // Line synchronizer. It resets to the idle level so that leaving reset
    // can never look like a start bit.
    // ------------------------------------------------------------------
    logic rx_meta;
    logic rx_s;

    always_ff @(posedge clk) begin
        if (rst) begin
            rx_meta <= 1'b1;
            rx_s    <= 1'b1;
        end else begin
            rx_meta <= rx;
            rx_s    <= rx_meta;
        end
    end

    // ------------------------------------------------------------------
    // Tick extraction. The baud generator toggles rx_tick once per
    // oversample period, so any difference from the last value is one tick.
    // ------------------------------------------------------------------
    logic tick_prev;
    logic tick;

    always_ff @(posedge clk) begin
        if (rst) begin
            tick_prev <= 1'b0;
        end else begin
            tick_prev <= rx_tick;
        end
    end

    assign tick = rx_tick ^ tick_prev;

    // ------------------------------------------------------------------
    // Receive FSM state.
    // ------------------------------------------------------------------
    logic [2:0]           state;
    logic [2:0]           state_n;
    logic [CNT_W-1:0]     cnt;
    logic [CNT_W-1:0]     cnt_n;
    logic [BIT_W-1:0]     bit_idx;
    logic [BIT_W-1:0]     bit_idx_n;
    logic [DATA_BITS-1:0] shift_reg;
    logic [DATA_BITS-1:0] shift_n;
    logic [DATA_BITS:0]   shift_cat;
    logic                 stop_ok;
    logic                 stop_bad;

    // Bits arrive LSB first. Each new sample enters at the top and moves
    // down, so the first bit ends in bit 0 after DATA_BITS samples.
    assign shift_cat = {rx_s, shift_reg};

    always_comb begin
        state_n   = state;
        cnt_n     = cnt;
        bit_idx_n = bit_idx;
        shift_n   = shift_reg;
        stop_ok   = 1'b0;
        stop_bad  = 1'b0;

        if (tick) begin
            case (state)
                S_IDLE: begin
                    if (!rx_s) begin
                        cnt_n   = '0;
                        state_n = S_START;
                    end
                end

                S_START: begin
                    if (cnt == CNT_HALF) begin
                        if (!rx_s) begin
                            cnt_n     = '0;
                            bit_idx_n = '0;
                            state_n   = S_DATA;
                        end else begin
                            // The line went high again: a glitch, not a
                            // start bit.
                            state_n = S_IDLE;
                        end
                    end else begin
                        cnt_n = cnt + CNT_ONE;
                    end
                end

                S_DATA: begin
                    if (cnt == CNT_LAST) begin
                        shift_n   = shift_cat[DATA_BITS:1];
                        cnt_n     = '0;
                        bit_idx_n = bit_idx + BIT_ONE;
                        if (bit_idx == BIT_LAST) begin
                            state_n = S_STOP;
                        end
                    end else begin
                        cnt_n = cnt + CNT_ONE;
                    end
                end

                S_STOP: begin
                    if (cnt == CNT_LAST) begin
                        cnt_n = '0;
                        if (rx_s) begin
                            stop_ok = 1'b1;
                            state_n = S_IDLE;
                        end else begin
                            // A low stop bit means a framing error or a break.
                            // Wait for the line to go high so one long break
                            // raises only one error.
                            stop_bad = 1'b1;
                            state_n  = S_WAIT_HIGH;
                        end
                    end else begin
                        cnt_n = cnt + CNT_ONE;
                    end
                end

                S_WAIT_HIGH: begin
                    if (rx_s) begin
                        state_n = S_IDLE;
                    end
                end

                default: begin
                    state_n = S_IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= S_IDLE;
            cnt       <= '0;
            bit_idx   <= '0;
            shift_reg <= '0;
        end else begin
            state     <= state_n;
            cnt       <= cnt_n;
            bit_idx   <= bit_idx_n;
            shift_reg <= shift_n;
        end
    end

    assign state_dbg = state;

    // ------------------------------------------------------------------
    // Output holding register and error pulses.
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            rx_data     <= '0;
            rx_valid    <= 1'b0;
            frame_err   <= 1'b0;
            overrun_err <= 1'b0;
        end else begin
            frame_err   <= stop_bad;
            overrun_err <= 1'b0;
            if (stop_ok) begin
                // The holding register is free when it is empty or is being
                // emptied in this same cycle.
                if (!rx_valid || rx_ready) begin
                    rx_data  <= shift_reg;
                    rx_valid <= 1'b1;
                end else begin
                    overrun_err <= 1'b1;
                end
            end else if (rx_valid && rx_ready) begin
                rx_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_uart_rx.sv
// -----------------------------------------------------------------------------
// tb_uart_rx -- directed testbench for uart_rx (DATA_BITS=8, OVERSAMPLE=16).
// Each oversample tick is one toggle of rx_tick, followed by 4 clk cycles.
// A frame takes ticks 0..159: start bit, 8 data bits LSB first, stop bit.
// The line takes 2 clk to reach rx_s through the synchronizer, so the start
// is seen on tick 1. The start is re-checked on tick 9, and the stop bit is
// sampled on tick 153. That tick's clock edge completes the word.
// -----------------------------------------------------------------------------
module tb_uart_rx;

    localparam int DATA_BITS    = 8;
    localparam int OS           = 16;
    localparam int CLK_PER_TICK = 4;
    localparam int STOP_TICK    = 153;

    localparam logic [2:0] S_IDLE      = 3'd0;
    localparam logic [2:0] S_START     = 3'd1;
    localparam logic [2:0] S_DATA      = 3'd2;
    localparam logic [2:0] S_WAIT_HIGH = 3'd4;

    // ---------------- clock / reset ----------------
    logic                 clk = 1'b0;
    logic                 rst;
    logic                 rx_tick;
    logic                 rx;
    logic                 rx_ready;
    logic [DATA_BITS-1:0] rx_data;
    logic                 rx_valid;
    logic                 frame_err;
    logic                 overrun_err;
    logic [2:0]           state_dbg;

    always #5 clk = ~clk;

    uart_rx #(
        .DATA_BITS (DATA_BITS),
        .OVERSAMPLE(OS)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .rx_tick    (rx_tick),
        .rx         (rx),
        .rx_data    (rx_data),
        .rx_valid   (rx_valid),
        .rx_ready   (rx_ready),
        .frame_err  (frame_err),
        .overrun_err(overrun_err),
        .state_dbg  (state_dbg)
    );

    // ---------------- scoreboard ----------------
    int n_checks = 0;
    int n_fail   = 0;
    int fe_cnt   = 0;
    int ov_cnt   = 0;
    logic [DATA_BITS-1:0] exp_q[$];

    always @(negedge clk) begin
        if (frame_err)   fe_cnt++;
        if (overrun_err) ov_cnt++;
    end

    // ---------------- driver tasks ----------------
    task automatic tick_once(input logic level, input bit ready_pulse);
        rx = level;
        if (ready_pulse) rx_ready = 1'b1;
        rx_tick = ~rx_tick;
        @(negedge clk);
        if (ready_pulse) rx_ready = 1'b0;
        repeat (CLK_PER_TICK - 1) @(negedge clk);
    endtask

    task automatic drive_frame(input logic [7:0] d, input logic stop_lvl,
                               input int first, input int last, input int ready_idx);
        for (int i = first; i <= last; i++) begin
            int   b;
            logic lvl;
            b = i / OS;
            if (b == 0)      lvl = 1'b0;
            else if (b <= 8) lvl = d[b-1];
            else             lvl = stop_lvl;
            tick_once(lvl, i == ready_idx);
        end
    endtask

    task automatic send_frame(input logic [7:0] d, input logic stop_lvl);
        drive_frame(d, stop_lvl, 0, 10 * OS - 1, -1);
    endtask

    task automatic idle_ticks(input int n, input logic level);
        for (int i = 0; i < n; i++) tick_once(level, 1'b0);
    endtask

    task automatic consume();
        rx_ready = 1'b1;
        @(negedge clk);
        rx_ready = 1'b0;
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        rst = 1'b1; rx = 1'b1; rx_tick = 1'b0; rx_ready = 1'b0;
        repeat (3) @(negedge clk);
        n_checks++; if (rx_data !== 8'h00) begin n_fail++; $display("FAIL reset_data: got %h expected 00", rx_data); end
        n_checks++; if (rx_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid: got %b expected 0", rx_valid); end
        n_checks++; if (frame_err !== 1'b0) begin n_fail++; $display("FAIL reset_frame_err: got %b expected 0", frame_err); end
        n_checks++; if (overrun_err !== 1'b0) begin n_fail++; $display("FAIL reset_overrun_err: got %b expected 0", overrun_err); end
        rst = 1'b0;
        @(negedge clk);
        n_checks++; if (state_dbg !== S_IDLE) begin n_fail++; $display("FAIL reset_state: got %0d expected %0d", state_dbg, S_IDLE); end
    endtask

    task automatic test_basic_frame();
        int fe0, ov0;
        logic [7:0] exp;
        fe0 = fe_cnt; ov0 = ov_cnt;
        exp_q.push_back(8'hA5);
        send_frame(8'hA5, 1'b1);
        idle_ticks(4, 1'b1);
        exp = exp_q.pop_front();
        n_checks++; if (rx_valid !== 1'b1) begin n_fail++; $display("FAIL basic_valid: got %b expected 1", rx_valid); end
        n_checks++; if (rx_data !== exp) begin n_fail++; $display("FAIL basic_data: got %h expected %h", rx_data, exp); end
        n_checks++; if (fe_cnt - fe0 != 0) begin n_fail++; $display("FAIL basic_frame_err: got %0d pulses expected 0", fe_cnt - fe0); end
        n_checks++; if (ov_cnt - ov0 != 0) begin n_fail++; $display("FAIL basic_overrun: got %0d pulses expected 0", ov_cnt - ov0); end
        repeat (5) @(negedge clk);
        n_checks++; if (rx_valid !== 1'b1) begin n_fail++; $display("FAIL basic_hold_valid: got %b expected 1", rx_valid); end
        consume();
        n_checks++; if (rx_valid !== 1'b0) begin n_fail++; $display("FAIL basic_consume: got %b expected 0", rx_valid); end
        // rx_ready while nothing is held must leave everything alone.
        rx_ready = 1'b1;
        repeat (3) @(negedge clk);
        rx_ready = 1'b0;
        n_checks++; if (rx_valid !== 1'b0) begin n_fail++; $display("FAIL idle_ready_valid: got %b expected 0", rx_valid); end
        n_checks++; if (rx_data !== 8'hA5) begin n_fail++; $display("FAIL idle_ready_data: got %h expected a5", rx_data); end
    endtask

    task automatic test_false_start();
        int fe0;
        fe0 = fe_cnt;
        idle_ticks(3, 1'b0);
        n_checks++; if (state_dbg !== S_START) begin n_fail++; $display("FAIL false_start_in_start: got %0d expected %0d", state_dbg, S_START); end
        idle_ticks(3, 1'b0);
        idle_ticks(20, 1'b1);
        n_checks++; if (state_dbg !== S_IDLE) begin n_fail++; $display("FAIL false_start_state: got %0d expected %0d", state_dbg, S_IDLE); end
        n_checks++; if (rx_valid !== 1'b0) begin n_fail++; $display("FAIL false_start_valid: got %b expected 0", rx_valid); end
        n_checks++; if (fe_cnt - fe0 != 0) begin n_fail++; $display("FAIL false_start_frame_err: got %0d pulses expected 0", fe_cnt - fe0); end
    endtask

    task automatic test_frame_error();
        int fe0, ov0;
        logic [7:0] exp;
        fe0 = fe_cnt; ov0 = ov_cnt;
        send_frame(8'h3C, 1'b0);
        idle_ticks(40, 1'b0);
        n_checks++; if (state_dbg !== S_WAIT_HIGH) begin n_fail++; $display("FAIL ferr_wait_high: got %0d expected %0d", state_dbg, S_WAIT_HIGH); end
        n_checks++; if (fe_cnt - fe0 != 1) begin n_fail++; $display("FAIL ferr_pulses: got %0d pulses expected 1", fe_cnt - fe0); end
        n_checks++; if (rx_valid !== 1'b0) begin n_fail++; $display("FAIL ferr_valid: got %b expected 0", rx_valid); end
        idle_ticks(4, 1'b1);
        n_checks++; if (state_dbg !== S_IDLE) begin n_fail++; $display("FAIL ferr_recover_state: got %0d expected %0d", state_dbg, S_IDLE); end
        exp_q.push_back(8'h55);
        send_frame(8'h55, 1'b1);
        idle_ticks(4, 1'b1);
        exp = exp_q.pop_front();
        n_checks++; if (rx_valid !== 1'b1) begin n_fail++; $display("FAIL ferr_next_valid: got %b expected 1", rx_valid); end
        n_checks++; if (rx_data !== exp) begin n_fail++; $display("FAIL ferr_next_data: got %h expected %h", rx_data, exp); end
        n_checks++; if (fe_cnt - fe0 != 1) begin n_fail++; $display("FAIL ferr_total_pulses: got %0d pulses expected 1", fe_cnt - fe0); end
        n_checks++; if (ov_cnt - ov0 != 0) begin n_fail++; $display("FAIL ferr_overrun: got %0d pulses expected 0", ov_cnt - ov0); end
        consume();
    endtask

    task automatic test_back_to_back();
        int ov0;
        logic [7:0] exp;
        ov0 = ov_cnt;
        exp_q.push_back(8'h11);
        send_frame(8'h11, 1'b1);
        idle_ticks(2, 1'b1);
        send_frame(8'h22, 1'b1);
        idle_ticks(4, 1'b1);
        exp = exp_q.pop_front();
        n_checks++; if (rx_data !== exp) begin n_fail++; $display("FAIL overrun_keep_data: got %h expected %h", rx_data, exp); end
        n_checks++; if (rx_valid !== 1'b1) begin n_fail++; $display("FAIL overrun_valid: got %b expected 1", rx_valid); end
        n_checks++; if (ov_cnt - ov0 != 1) begin n_fail++; $display("FAIL overrun_pulses: got %0d pulses expected 1", ov_cnt - ov0); end
        consume();
        n_checks++; if (rx_valid !== 1'b0) begin n_fail++; $display("FAIL overrun_consume: got %b expected 0", rx_valid); end

        // Second pass: take 0x11 in the same cycle that 0x22 completes.
        ov0 = ov_cnt;
        send_frame(8'h11, 1'b1);
        idle_ticks(2, 1'b1);
        exp_q.push_back(8'h22);
        drive_frame(8'h22, 1'b1, 0, 10 * OS - 1, STOP_TICK);
        idle_ticks(4, 1'b1);
        exp = exp_q.pop_front();
        n_checks++; if (rx_data !== exp) begin n_fail++; $display("FAIL same_cycle_data: got %h expected %h", rx_data, exp); end
        n_checks++; if (rx_valid !== 1'b1) begin n_fail++; $display("FAIL same_cycle_valid: got %b expected 1", rx_valid); end
        n_checks++; if (ov_cnt - ov0 != 0) begin n_fail++; $display("FAIL same_cycle_overrun: got %0d pulses expected 0", ov_cnt - ov0); end
    endtask

    task automatic test_reset_mid_frame();
        int fe0, ov0;
        logic [7:0] exp;
        fe0 = fe_cnt; ov0 = ov_cnt;
        // 0x22 from the previous test is still held, so reset has something to clear.
        drive_frame(8'hF0, 1'b1, 0, 5 * OS + 7, -1);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        n_checks++; if (rx_data !== 8'h00) begin n_fail++; $display("FAIL midrst_data: got %h expected 00", rx_data); end
        n_checks++; if (rx_valid !== 1'b0) begin n_fail++; $display("FAIL midrst_valid: got %b expected 0", rx_valid); end
        n_checks++; if (state_dbg !== S_IDLE) begin n_fail++; $display("FAIL midrst_state: got %0d expected %0d", state_dbg, S_IDLE); end
        n_checks++; if (frame_err !== 1'b0 || overrun_err !== 1'b0) begin n_fail++; $display("FAIL midrst_errs: got %b%b expected 00", frame_err, overrun_err); end
        // The rest of 0xF0 (bits 4..7 and stop) is all high.
        idle_ticks(10 * OS - (5 * OS + 8), 1'b1);
        exp_q.push_back(8'h0F);
        send_frame(8'h0F, 1'b1);
        idle_ticks(4, 1'b1);
        exp = exp_q.pop_front();
        n_checks++; if (rx_data !== exp) begin n_fail++; $display("FAIL midrst_next_data: got %h expected %h", rx_data, exp); end
        n_checks++; if (rx_valid !== 1'b1) begin n_fail++; $display("FAIL midrst_next_valid: got %b expected 1", rx_valid); end
        n_checks++; if (fe_cnt - fe0 != 0 || ov_cnt - ov0 != 0) begin n_fail++; $display("FAIL midrst_no_err: got %0d/%0d pulses expected 0/0", fe_cnt - fe0, ov_cnt - ov0); end
        consume();
    endtask

    task automatic test_tick_stall();
        logic [7:0] exp;
        exp_q.push_back(8'h96);
        drive_frame(8'h96, 1'b1, 0, 69, -1);
        n_checks++; if (state_dbg !== S_DATA) begin n_fail++; $display("FAIL stall_pre_state: got %0d expected %0d", state_dbg, S_DATA); end
        repeat (100) @(negedge clk);
        n_checks++; if (state_dbg !== S_DATA) begin n_fail++; $display("FAIL stall_state: got %0d expected %0d", state_dbg, S_DATA); end
        n_checks++; if (rx_valid !== 1'b0) begin n_fail++; $display("FAIL stall_valid: got %b expected 0", rx_valid); end
        drive_frame(8'h96, 1'b1, 70, 10 * OS - 1, -1);
        idle_ticks(4, 1'b1);
        exp = exp_q.pop_front();
        n_checks++; if (rx_data !== exp) begin n_fail++; $display("FAIL stall_data: got %h expected %h", rx_data, exp); end
        n_checks++; if (rx_valid !== 1'b1) begin n_fail++; $display("FAIL stall_done_valid: got %b expected 1", rx_valid); end
        consume();
    endtask

    // ---------------- sequence and report ----------------
    initial begin
        test_reset();
        test_basic_frame();
        test_false_start();
        test_frame_error();
        test_back_to_back();
        test_reset_mid_frame();
        test_tick_stall();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
